// File: rtl/bp_update_sched.sv
// Branch predictor update scheduler: queues up to two EX resolutions per cycle and
// issues them over one table write port, and walks all indices on a table flush.
// Optional feature: define BP_UPD_COALESCE_EN to merge same-index dual branch updates.
`timescale 1ns/1ps
module bp_update_sched #(
  parameter int BhtSize   = 16,
  parameter int FifoDepth = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pdt_en_cfg_i,
  input  logic [31:0] tbl_rst_val_i,
  input  logic        flush_req_i,
  input  logic [1:0]  ex_valid_i,
  input  logic [1:0]  ex_is_jal_i,
  input  logic [1:0]  ex_taken_i,
  input  logic [31:0] ex_pc0_i,
  input  logic [31:0] ex_pc1_i,
  input  logic [31:0] ex_target0_i,
  input  logic [31:0] ex_target1_i,
  input  logic        upd_ready_i,
  output logic        upd_valid_o,
  output logic        upd_init_o,
  output logic        upd_is_jal_o,
  output logic        upd_taken_o,
  output logic [31:0] upd_pc_o,
  output logic [31:0] upd_target_o,
  output logic        pdt_en_o,
  output logic        busy_o,
  output logic        flush_done_o,
  output logic [15:0] drop_cnt_o
);

  localparam int IdxW = $clog2(BhtSize);
  localparam int PtrW = $clog2(FifoDepth);

  typedef enum logic {IDLE, FLUSH} state_e;

  typedef struct packed {
    logic        is_jal;
    logic        taken;
    logic [31:0] pc;
    logic [31:0] target;
  } upd_entry_t;

  state_e            state_reg, state_next;
  logic [IdxW-1:0]   idx_reg, idx_next;
  logic              done_reg, done_next;
  logic [15:0]       drop_reg, drop_next;
  logic [PtrW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PtrW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PtrW:0]     cnt_reg, cnt_next;
  upd_entry_t        mem_reg [FifoDepth];

  upd_entry_t        slot0_entry, slot1_entry, first_entry;
  logic [1:0]        slot_vld;
  logic [1:0]        n_req, n_acc, n_drop;
  logic [PtrW:0]     free_slots;
  logic              enq_allow, pop, wr0_en, wr1_en;
  logic [PtrW-1:0]   wr_ptr_p1;
  logic [16:0]       drop_sum;

  assign slot0_entry = '{is_jal: ex_is_jal_i[0], taken: ex_taken_i[0],
                         pc: ex_pc0_i, target: ex_target0_i};
  assign slot1_entry = '{is_jal: ex_is_jal_i[1], taken: ex_taken_i[1],
                         pc: ex_pc1_i, target: ex_target1_i};

  always_comb begin
    slot_vld = ex_valid_i;
`ifdef BP_UPD_COALESCE_EN
    // Both branches hit the same predictor index: the younger outcome wins.
    if ((&ex_valid_i) && ~(|ex_is_jal_i) && (ex_pc0_i[IdxW:1] == ex_pc1_i[IdxW:1]))
      slot_vld = 2'b10;
`endif
  end

  // Space is judged on start-of-cycle occupancy; a concurrent pop does not help.
  assign n_req       = {1'b0, slot_vld[0]} + {1'b0, slot_vld[1]};
  assign free_slots  = (PtrW+1)'(FifoDepth) - cnt_reg;
  assign n_acc       = (free_slots >= (PtrW+1)'(n_req)) ? n_req : free_slots[1:0];
  assign n_drop      = n_req - n_acc;
  assign first_entry = slot_vld[0] ? slot0_entry : slot1_entry;

  assign enq_allow = (state_reg == IDLE) && !flush_req_i;
  assign pop       = (state_reg == IDLE) && (cnt_reg != '0) && upd_ready_i;
  assign wr0_en    = enq_allow && (n_acc != 2'd0);
  assign wr1_en    = enq_allow && (n_acc == 2'd2);
  assign wr_ptr_p1 = wr_ptr_reg + 1'b1;
  assign drop_sum  = {1'b0, drop_reg} + {15'd0, n_drop};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      done_reg   <= 1'b0;
      drop_reg   <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      done_reg   <= done_next;
      drop_reg   <= drop_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Storage is never reset; outputs are gated by occupancy instead.
  for (genvar gi = 0; gi < FifoDepth; gi++) begin : g_mem
    always_ff @(posedge clk_i) begin
      if (wr0_en && (wr_ptr_reg == PtrW'(gi)))
        mem_reg[gi] <= first_entry;
      else if (wr1_en && (wr_ptr_p1 == PtrW'(gi)))
        mem_reg[gi] <= slot1_entry;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    done_next   = 1'b0;
    drop_next   = drop_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (flush_req_i) begin
          state_next  = FLUSH;
          idx_next    = '0;
          rd_ptr_next = '0;
          wr_ptr_next = '0;
          cnt_next    = '0;
        end else begin
          rd_ptr_next = rd_ptr_reg + PtrW'(pop);
          wr_ptr_next = wr_ptr_reg + PtrW'(n_acc);
          cnt_next    = cnt_reg - (PtrW+1)'(pop) + (PtrW+1)'(n_acc);
          drop_next   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
      end
      FLUSH: begin
        if (flush_req_i) begin
          idx_next = '0;
        end else if (upd_ready_i) begin
          if (idx_reg == IdxW'(BhtSize - 1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    upd_valid_o  = 1'b0;
    upd_init_o   = 1'b0;
    upd_is_jal_o = 1'b0;
    upd_taken_o  = 1'b0;
    upd_pc_o     = '0;
    upd_target_o = '0;
    if (state_reg == FLUSH) begin
      upd_valid_o  = 1'b1;
      upd_init_o   = 1'b1;
      upd_pc_o     = 32'({idx_reg, 1'b0});
      upd_target_o = tbl_rst_val_i;
    end else if (cnt_reg != '0) begin
      upd_valid_o  = 1'b1;
      upd_is_jal_o = mem_reg[rd_ptr_reg].is_jal;
      upd_taken_o  = mem_reg[rd_ptr_reg].taken;
      upd_pc_o     = mem_reg[rd_ptr_reg].pc;
      upd_target_o = mem_reg[rd_ptr_reg].target;
    end
  end

  assign pdt_en_o     = pdt_en_cfg_i && (state_reg == IDLE);
  assign busy_o       = (state_reg == FLUSH);
  assign flush_done_o = done_reg;
  assign drop_cnt_o   = drop_reg;

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed self-checking bench for bp_update_sched: issue path, overflow drops,
// flush walk, flush restart under backpressure, coalescing and reset mid-flush.
`timescale 1ns/1ps
module tb_bp_update_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        pdt_en_cfg_i;
  logic [31:0] tbl_rst_val_i;
  logic        flush_req_i;
  logic [1:0]  ex_valid_i, ex_is_jal_i, ex_taken_i;
  logic [31:0] ex_pc0_i, ex_pc1_i, ex_target0_i, ex_target1_i;
  logic        upd_ready_i;
  logic        upd_valid_o, upd_init_o, upd_is_jal_o, upd_taken_o;
  logic [31:0] upd_pc_o, upd_target_o;
  logic        pdt_en_o, busy_o, flush_done_o;
  logic [15:0] drop_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  bp_update_sched #(.BhtSize(16), .FifoDepth(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pdt_en_cfg_i(pdt_en_cfg_i),
    .tbl_rst_val_i(tbl_rst_val_i), .flush_req_i(flush_req_i),
    .ex_valid_i(ex_valid_i), .ex_is_jal_i(ex_is_jal_i), .ex_taken_i(ex_taken_i),
    .ex_pc0_i(ex_pc0_i), .ex_pc1_i(ex_pc1_i),
    .ex_target0_i(ex_target0_i), .ex_target1_i(ex_target1_i),
    .upd_ready_i(upd_ready_i), .upd_valid_o(upd_valid_o), .upd_init_o(upd_init_o),
    .upd_is_jal_o(upd_is_jal_o), .upd_taken_o(upd_taken_o),
    .upd_pc_o(upd_pc_o), .upd_target_o(upd_target_o),
    .pdt_en_o(pdt_en_o), .busy_o(busy_o), .flush_done_o(flush_done_o),
    .drop_cnt_o(drop_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [1:0] v, input logic [1:0] jal, input logic [1:0] tk,
                      input logic [31:0] p0, input logic [31:0] p1,
                      input logic [31:0] t0, input logic [31:0] t1);
    ex_valid_i = v; ex_is_jal_i = jal; ex_taken_i = tk;
    ex_pc0_i = p0; ex_pc1_i = p1; ex_target0_i = t0; ex_target1_i = t1;
    $display("tx v=%b pc0=0x%08h pc1=0x%08h", v, p0, p1);
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                             input logic jal, input logic tk);
    check({tag, ".valid"}, 32'(upd_valid_o), 32'd1);
    check({tag, ".init"}, 32'(upd_init_o), 32'd0);
    check({tag, ".pc"}, upd_pc_o, pc);
    check({tag, ".target"}, upd_target_o, tgt);
    check({tag, ".jal"}, 32'(upd_is_jal_o), 32'(jal));
    check({tag, ".taken"}, 32'(upd_taken_o), 32'(tk));
  endtask

  initial begin
    rst_ni = 1'b0; pdt_en_cfg_i = 1'b0; tbl_rst_val_i = 32'h8000_0000;
    flush_req_i = 1'b0; upd_ready_i = 1'b0;
    ex_valid_i = '0; ex_is_jal_i = '0; ex_taken_i = '0;
    ex_pc0_i = '0; ex_pc1_i = '0; ex_target0_i = '0; ex_target1_i = '0;

    // Reset state
    step(); step();
    check("rst.valid", 32'(upd_valid_o), 32'd0);
    check("rst.init", 32'(upd_init_o), 32'd0);
    check("rst.pc", upd_pc_o, 32'd0);
    check("rst.target", upd_target_o, 32'd0);
    check("rst.busy", 32'(busy_o), 32'd0);
    check("rst.done", 32'(flush_done_o), 32'd0);
    check("rst.drop", 32'(drop_cnt_o), 32'd0);
    check("rst.pdt_en", 32'(pdt_en_o), 32'd0);
    rst_ni = 1'b1; pdt_en_cfg_i = 1'b1;
    step();

    // Single update, one cycle latency, then empty
    upd_ready_i = 1'b1;
    send(2'b01, 2'b00, 2'b01, 32'h100, 32'h0, 32'h200, 32'h0);
    check("single.pre_valid", 32'(upd_valid_o), 32'd0);
    step();
    ex_valid_i = 2'b00;
    expect_head("single", 32'h100, 32'h200, 1'b0, 1'b1);
    step();
    check("single.empty", 32'(upd_valid_o), 32'd0);

    // Overflow: three dual cycles with no ready
    upd_ready_i = 1'b0;
    send(2'b11, 2'b10, 2'b01, 32'h1000, 32'h1004, 32'h2000, 32'h2004); step();
    send(2'b11, 2'b10, 2'b01, 32'h1040, 32'h1044, 32'h2040, 32'h2044); step();
    send(2'b11, 2'b10, 2'b01, 32'h1080, 32'h1084, 32'h2080, 32'h2084); step();
    check("ovf.drop", 32'(drop_cnt_o), 32'd2);
    // Release ready while still full: this cycle's pop does not make room
    upd_ready_i = 1'b1;
    send(2'b11, 2'b00, 2'b00, 32'h10C0, 32'h10C4, 32'h20C0, 32'h20C4);
    expect_head("ovf0", 32'h1000, 32'h2000, 1'b0, 1'b1);
    step(); ex_valid_i = 2'b00;
    check("ovf.drop_full", 32'(drop_cnt_o), 32'd4);
    expect_head("ovf1", 32'h1004, 32'h2004, 1'b1, 1'b0); step();
    expect_head("ovf2", 32'h1040, 32'h2040, 1'b0, 1'b1); step();
    expect_head("ovf3", 32'h1044, 32'h2044, 1'b1, 1'b0); step();
    check("ovf.empty", 32'(upd_valid_o), 32'd0);

    // One free slot with two pending: slot 0 kept, slot 1 dropped
    upd_ready_i = 1'b0;
    send(2'b01, 2'b00, 2'b00, 32'h3000, 32'h0, 32'h3100, 32'h0); step();
    send(2'b11, 2'b00, 2'b11, 32'h3040, 32'h3044, 32'h3140, 32'h3144); step();
    send(2'b11, 2'b00, 2'b11, 32'h3080, 32'h3084, 32'h3180, 32'h3184); step();
    ex_valid_i = 2'b00;
    check("part.drop", 32'(drop_cnt_o), 32'd5);
    upd_ready_i = 1'b1;
    expect_head("part0", 32'h3000, 32'h3100, 1'b0, 1'b0); step();
    expect_head("part1", 32'h3040, 32'h3140, 1'b0, 1'b1); step();
    expect_head("part2", 32'h3044, 32'h3144, 1'b0, 1'b1); step();
    expect_head("part3", 32'h3080, 32'h3180, 1'b0, 1'b1); step();
    check("part.empty", 32'(upd_valid_o), 32'd0);

    // Full flush with ready high; EX traffic around it is discarded
    flush_req_i = 1'b1;
    send(2'b11, 2'b00, 2'b00, 32'h4000, 32'h4004, 32'h0, 32'h0);
    check("fl.pdt_req", 32'(pdt_en_o), 32'd1);
    step();
    flush_req_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) send(2'b11, 2'b00, 2'b00, 32'h5000, 32'h5004, 32'h0, 32'h0);
      else ex_valid_i = 2'b00;
      check($sformatf("fl.valid%0d", i), 32'(upd_valid_o), 32'd1);
      check($sformatf("fl.init%0d", i), 32'(upd_init_o), 32'd1);
      check($sformatf("fl.pc%0d", i), upd_pc_o, 32'(2 * i));
      check($sformatf("fl.tgt%0d", i), upd_target_o, 32'h8000_0000);
      check($sformatf("fl.pdt%0d", i), 32'(pdt_en_o), 32'd0);
      check($sformatf("fl.done%0d", i), 32'(flush_done_o), 32'd0);
      step();
    end
    check("fl.done", 32'(flush_done_o), 32'd1);
    check("fl.pdt_back", 32'(pdt_en_o), 32'd1);
    check("fl.busy_end", 32'(busy_o), 32'd0);
    check("fl.fifo_clear", 32'(upd_valid_o), 32'd0);
    check("fl.drop_same", 32'(drop_cnt_o), 32'd5);
    step();
    check("fl.done_pulse", 32'(flush_done_o), 32'd0);

    // Flush with alternating ready and a restart at idx=5
    flush_req_i = 1'b1; step(); flush_req_i = 1'b0;
    begin
      int dones = 0;
      for (int c = 0; c < 50; c++) begin
        upd_ready_i = (c % 2 == 0);
        flush_req_i = (c == 9);
        if (c <= 40)
          check($sformatf("rs.pc%0d", c), upd_pc_o,
                32'(2 * ((c < 10) ? (c + 1) / 2 : (c - 9) / 2)));
        check($sformatf("rs.busy%0d", c), 32'(busy_o), 32'(c <= 40));
        check($sformatf("rs.done%0d", c), 32'(flush_done_o), 32'(c == 41));
        if (flush_done_o) dones++;
        step();
      end
      flush_req_i = 1'b0;
      check("rs.done_count", 32'(dones), 32'd1);
    end

    // Same-index dual branches at 0x10 / 0x30
    upd_ready_i = 1'b0;
    send(2'b11, 2'b00, 2'b01, 32'h10, 32'h30, 32'hA0, 32'hB0); step();
    ex_valid_i = 2'b00;
`ifdef BP_UPD_COALESCE_EN
    expect_head("co.merged", 32'h30, 32'hB0, 1'b0, 1'b0);
    upd_ready_i = 1'b1; step();
`else
    expect_head("co.first", 32'h10, 32'hA0, 1'b0, 1'b1);
    upd_ready_i = 1'b1; step();
    expect_head("co.second", 32'h30, 32'hB0, 1'b0, 1'b0); step();
`endif
    check("co.empty", 32'(upd_valid_o), 32'd0);
    check("co.drop", 32'(drop_cnt_o), 32'd5);

    // Reset asserted mid-flush at idx=7
    flush_req_i = 1'b1; step(); flush_req_i = 1'b0;
    repeat (7) step();
    check("mr.pc7", upd_pc_o, 32'h0E);
    rst_ni = 1'b0;
    #1;
    check("mr.busy", 32'(busy_o), 32'd0);
    check("mr.valid", 32'(upd_valid_o), 32'd0);
    check("mr.drop", 32'(drop_cnt_o), 32'd0);
    step();
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("mr.post_done%0d", k), 32'(flush_done_o), 32'd0);
      check($sformatf("mr.post_busy%0d", k), 32'(busy_o), 32'd0);
      check($sformatf("mr.post_valid%0d", k), 32'(upd_valid_o), 32'd0);
    end
    check("mr.pdt_en", 32'(pdt_en_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_update_sched.md
# bp_update_sched

Update scheduler for the branch predictor tables. It takes up to two EX-stage branch/jal resolutions per cycle and queues them in a small FIFO. It issues them one per cycle over a single write port into the BHT/BTB/JTB, and it sequences full-table flushes by walking every index with the reset target value. It sits between the EX stage and the predictor, and gates prediction enable while a flush is in progress.

## Interface
- `BhtSize`, 16: predictor entries walked on flush; power of two, ≥2.
- `FifoDepth`, 4: update queue entries; power of two, ≥2.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `pdt_en_cfg_i` input 1: software prediction enable.
- `tbl_rst_val_i` input 32: target value written during flush.
- `flush_req_i` input 1: request a full table flush (level-sampled each cycle).
- `ex_valid_i` input 2: per-slot resolution valid; slot 0 is older.
- `ex_is_jal_i` input 2: 1 = jal update, 0 = branch update.
- `ex_taken_i` input 2: resolved direction (ignored for jal).
- `ex_pc0_i`, `ex_pc1_i` input 32: slot PCs.
- `ex_target0_i`, `ex_target1_i` input 32: resolved targets.
- `upd_ready_i` input 1: table write port accepts this cycle.
- `upd_valid_o` output 1: write request valid.
- `upd_init_o` output 1: write is a flush write (all tables, valid cleared).
- `upd_is_jal_o` output 1: update kind.
- `upd_taken_o` output 1: direction.
- `upd_pc_o` output 32: PC, or `{idx,1'b0}` during flush.
- `upd_target_o` output 32: target.
- `pdt_en_o` output 1: `pdt_en_cfg_i & (state==IDLE)`.
- `busy_o` output 1: state==FLUSH.
- `flush_done_o` output 1: one-cycle pulse after the last flush write is accepted.
- `drop_cnt_o` output 16: dropped updates, saturating.

## Operation
- States are IDLE and FLUSH. All outputs reset to 0; the FIFO resets empty and the state resets to IDLE.
- IDLE:
  - The FIFO head drives `upd_*` with `upd_valid_o = ~empty` and `upd_init_o = 0`.
  - The head is popped when `upd_valid_o & upd_ready_i`.
- Enqueue:
  - Valid slots are written in order, slot 0 first.
  - Free space is computed from the occupancy at the start of the cycle; a same-cycle pop is not credited.
  - If two updates are pending and only one slot is free: enqueue slot 0, drop slot 1.
  - If the FIFO is full, drop all pending updates.
  - `drop_cnt_o` increments by the number dropped and saturates at 0xFFFF.
- `flush_req_i` in IDLE:
  - Next cycle the state is FLUSH, the FIFO is cleared, and the index is 0.
  - EX updates arriving in the same cycle as the request are discarded and not counted as drops.
- FLUSH:
  - Outputs: `upd_valid_o = 1`, `upd_init_o = 1`, `upd_pc_o = {idx,1'b0}`, `upd_target_o = tbl_rst_val_i`, `upd_taken_o = 0`, `upd_is_jal_o = 0`.
  - The index advances on `upd_ready_i`.
  - When `idx == BhtSize-1` is accepted: return to IDLE and pulse `flush_done_o` in the following cycle.
  - EX updates during FLUSH are discarded and not counted.
  - `flush_req_i` during FLUSH restarts the index at 0; no `flush_done_o` pulse is generated for the aborted walk.
- Index arithmetic: the index is `$clog2(BhtSize)` bits. The terminal test is an exact compare, with no wrap beyond `BhtSize-1`.

## Timing
- From `ex_valid_i` to `upd_valid_o` is 1 cycle when the FIFO is empty (registered, no bypass).
- With continuous `upd_ready_i`, throughput is 1 update/cycle.
- Two updates in a cycle occupy 2 consecutive issue cycles.
- A flush takes `BhtSize` cycles with `upd_ready_i` held high, plus 1 cycle of entry latency.
- `pdt_en_o` drops in the cycle after `flush_req_i` and rises in the same cycle that `flush_done_o` pulses.
- Reset asserted mid-flush aborts immediately to IDLE: FIFO empty, `drop_cnt_o = 0`, no done pulse.

## Configuration
- `BP_UPD_COALESCE_EN` defined:
  - Applies when both slots are valid, neither is jal, and `ex_pc0_i[$clog2(BhtSize):1] == ex_pc1_i[$clog2(BhtSize):1]`.
  - Only slot 1 is enqueued, as one entry; slot 0 is not counted as a drop.
- `BP_UPD_COALESCE_EN` undefined: both slots are enqueued in order.

## Test plan
- Single update: empty FIFO, slot 0 valid with pc=0x100, taken=1, target=0x200, `upd_ready_i = 1` → next cycle `upd_valid_o = 1`, `upd_pc_o = 0x100`, `upd_target_o = 0x200`; the cycle after that, `upd_valid_o = 0`.
- Overflow: `upd_ready_i = 0`, FifoDepth=4; issue 3 cycles of dual updates → 4 entries queued, `drop_cnt_o = 2`; release ready → 4 issues in order, slot0/slot1 interleaved by cycle.
- Flush: `flush_req_i` pulse, `tbl_rst_val_i = 0x8000_0000`, BhtSize=16, ready held high → 16 init writes with `upd_pc_o` 0x0..0x1E step 2; `pdt_en_o = 0` throughout; `flush_done_o` pulses 17 cycles after the request.
- Flush backpressure and restart: toggle `upd_ready_i`, and assert `flush_req_i` again at idx=5 → the index returns to 0 and exactly one done pulse is produced, after a full walk.
- Coalesce: dual branches at pc 0x10 and 0x30 (same index for BhtSize=16) → one entry with the slot 1 data when the macro is defined, two entries when it is undefined.
- Reset mid-flush at idx=7 → after deassertion: IDLE, `upd_valid_o = 0`, `busy_o = 0`, `drop_cnt_o = 0`.
